// File: rtl/decode_stage_if.sv
// Handshake and data bundle between fetch, decode, the register file and execute.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_stage_if #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter int REG_IDX   = 5
);
  logic                 startSig;
  logic                 interrupt_start;
  logic [XLEN-1:0]      fetch_data;
  logic [ADDR_SIZE-1:0] fetch_cur_pc;
  logic [ADDR_SIZE-1:0] fetch_nxt_pc;
  logic                 beforePipReadyToSend;
  logic                 nextPipReadyToRcv;
  logic                 wb_en;
  logic [REG_IDX-1:0]   wb_idx;
  logic [XLEN-1:0]      rf_rs1_data;
  logic [XLEN-1:0]      rf_rs2_data;
  logic [REG_IDX-1:0]   rf_rs1_idx;
  logic [REG_IDX-1:0]   rf_rs2_idx;
  logic                 curPipReadyToRcv;
  logic                 curPipReadyToSend;
  logic [3:0]           dec_op;
  logic [2:0]           dec_funct3;
  logic                 dec_funct7b5;
  logic [REG_IDX-1:0]   dec_rd_idx;
  logic [XLEN-1:0]      dec_imm;
  logic [XLEN-1:0]      dec_rs1_val;
  logic [XLEN-1:0]      dec_rs2_val;
  logic [ADDR_SIZE-1:0] dec_cur_pc;
  logic [ADDR_SIZE-1:0] dec_nxt_pc;
  logic                 dec_illegal;

  modport slave (
    input  startSig, interrupt_start, fetch_data, fetch_cur_pc, fetch_nxt_pc,
           beforePipReadyToSend, nextPipReadyToRcv, wb_en, wb_idx,
           rf_rs1_data, rf_rs2_data,
    output rf_rs1_idx, rf_rs2_idx, curPipReadyToRcv, curPipReadyToSend,
           dec_op, dec_funct3, dec_funct7b5, dec_rd_idx, dec_imm,
           dec_rs1_val, dec_rs2_val, dec_cur_pc, dec_nxt_pc, dec_illegal
  );

  modport master (
    output startSig, interrupt_start, fetch_data, fetch_cur_pc, fetch_nxt_pc,
           beforePipReadyToSend, nextPipReadyToRcv, wb_en, wb_idx,
           rf_rs1_data, rf_rs2_data,
    input  rf_rs1_idx, rf_rs2_idx, curPipReadyToRcv, curPipReadyToSend,
           dec_op, dec_funct3, dec_funct7b5, dec_rd_idx, dec_imm,
           dec_rs1_val, dec_rs2_val, dec_cur_pc, dec_nxt_pc, dec_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: registers one instruction from fetch, decodes it, and holds it
// until its source registers are clear of in-flight writes before handing it to execute.
//
// state       | meaning
// ST_IDLE     | after reset, waiting for startSig
// ST_WAIT_BEF | empty, ready to accept from fetch
// ST_HOLD     | instruction held, sent once sources are not busy
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter int REG_IDX   = 5
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  localparam int NREG = 1 << REG_IDX;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] CLS_LUI     = 4'd0;
  localparam logic [3:0] CLS_AUIPC   = 4'd1;
  localparam logic [3:0] CLS_JAL     = 4'd2;
  localparam logic [3:0] CLS_JALR    = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_LOAD    = 4'd5;
  localparam logic [3:0] CLS_STORE   = 4'd6;
  localparam logic [3:0] CLS_OPIMM   = 4'd7;
  localparam logic [3:0] CLS_OP      = 4'd8;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BEF = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0]      r_instr;
  logic [ADDR_SIZE-1:0] r_cur_pc;
  logic [ADDR_SIZE-1:0] r_nxt_pc;
  logic [3:0]           r_op;
  logic [REG_IDX-1:0]   r_rd;
  logic [XLEN-1:0]      r_imm;
  logic                 r_illegal;
  logic                 r_uses_rs1;
  logic                 r_uses_rs2;
  logic [NREG-1:0]      r_busy;

  logic                 w_flush;
  logic                 w_stall;
  logic                 w_ready_send;
  logic                 w_ready_rcv;
  logic                 w_send;
  logic                 w_accept;
  logic [NREG-1:0]      w_busy_nxt;

  logic [6:0]           w_opc;
  logic [XLEN-1:0]      w_in;
  logic [3:0]           w_op;
  logic [REG_IDX-1:0]   w_rd;
  logic [XLEN-1:0]      w_imm;
  logic                 w_illegal;
  logic                 w_uses_rs1;
  logic                 w_uses_rs2;
  logic [REG_IDX-1:0]   w_rs1;
  logic [REG_IDX-1:0]   w_rs2;

  // Combinational decode of the word fetch is offering; captured only on accept.
  assign w_in  = bus.fetch_data;
  assign w_opc = w_in[6:0];

  always_comb begin
    w_op       = CLS_ILLEGAL;
    w_imm      = '0;
    w_rd       = w_in[11:7];
    w_illegal  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        w_op  = CLS_LUI;
        w_imm = {w_in[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        w_op  = CLS_AUIPC;
        w_imm = {w_in[31:12], 12'b0};
      end
      OPC_JAL: begin
        w_op  = CLS_JAL;
        w_imm = {{12{w_in[31]}}, w_in[19:12], w_in[20], w_in[30:21], 1'b0};
      end
      OPC_JALR: begin
        w_op       = CLS_JALR;
        w_imm      = {{20{w_in[31]}}, w_in[31:20]};
        w_uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        w_op       = CLS_BRANCH;
        w_imm      = {{20{w_in[31]}}, w_in[7], w_in[30:25], w_in[11:8], 1'b0};
        w_rd       = '0;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        w_op       = CLS_LOAD;
        w_imm      = {{20{w_in[31]}}, w_in[31:20]};
        w_uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        w_op       = CLS_STORE;
        w_imm      = {{20{w_in[31]}}, w_in[31:25], w_in[11:7]};
        w_rd       = '0;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        w_op       = CLS_OPIMM;
        w_imm      = {{20{w_in[31]}}, w_in[31:20]};
        w_uses_rs1 = 1'b1;
      end
      OPC_OP: begin
        w_op       = CLS_OP;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      default: begin
        w_op      = CLS_ILLEGAL;
        w_rd      = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_rs1   = r_instr[19:15];
  assign w_rs2   = r_instr[24:20];
  assign w_flush = bus.startSig | bus.interrupt_start;
  assign w_stall = (r_uses_rs1 & r_busy[w_rs1]) | (r_uses_rs2 & r_busy[w_rs2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush blocks both transfers in its cycle so nothing escapes into execute.
  always_comb begin
    w_state_nxt  = r_state;
    w_ready_send = (r_state == ST_HOLD) & ~w_stall;
    w_ready_rcv  = (r_state == ST_WAIT_BEF) | (w_ready_send & bus.nextPipReadyToRcv);
    w_send       = w_ready_send & bus.nextPipReadyToRcv & ~w_flush;
    w_accept     = bus.beforePipReadyToSend & w_ready_rcv & ~w_flush;
    if (w_flush) begin
      w_state_nxt = ST_WAIT_BEF;
    end else begin
      case (r_state)
        ST_IDLE:     w_state_nxt = ST_IDLE;
        ST_WAIT_BEF: if (w_accept) w_state_nxt = ST_HOLD;
        ST_HOLD: begin
          if (w_accept)    w_state_nxt = ST_HOLD;
          else if (w_send) w_state_nxt = ST_WAIT_BEF;
        end
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Set after clear so a same-cycle send to a register being written back wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (bus.wb_en) w_busy_nxt[bus.wb_idx] = 1'b0;
      if (w_send && (r_rd != '0)) w_busy_nxt[r_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= '0;
      r_cur_pc   <= '0;
      r_nxt_pc   <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_illegal  <= 1'b0;
      r_uses_rs1 <= 1'b0;
      r_uses_rs2 <= 1'b0;
    end else if (w_accept) begin
      r_instr    <= w_in;
      r_cur_pc   <= bus.fetch_cur_pc;
      r_nxt_pc   <= bus.fetch_nxt_pc;
      r_op       <= w_op;
      r_rd       <= w_rd;
      r_imm      <= w_imm;
      r_illegal  <= w_illegal;
      r_uses_rs1 <= w_uses_rs1;
      r_uses_rs2 <= w_uses_rs2;
    end
  end

  assign bus.curPipReadyToSend = w_ready_send;
  assign bus.curPipReadyToRcv  = w_ready_rcv;
  assign bus.rf_rs1_idx        = w_rs1;
  assign bus.rf_rs2_idx        = w_rs2;
  assign bus.dec_op            = r_op;
  assign bus.dec_funct3        = r_instr[14:12];
  assign bus.dec_funct7b5      = r_instr[30];
  assign bus.dec_rd_idx        = r_rd;
  assign bus.dec_imm           = r_imm;
  assign bus.dec_rs1_val       = bus.rf_rs1_data;
  assign bus.dec_rs2_val       = bus.rf_rs2_data;
  assign bus.dec_cur_pc        = r_cur_pc;
  assign bus.dec_nxt_pc        = r_nxt_pc;
  assign bus.dec_illegal       = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against an arithmetic RV32I decode
// model and a simple busy-register model kept in the bench.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage_if bus_if ();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus_if));

  assign bus_if.rf_rs1_data = 32'hA000_0000 | 32'(bus_if.rf_rs1_idx);
  assign bus_if.rf_rs2_data = 32'hB000_0000 | 32'(bus_if.rf_rs2_idx);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_class(input logic [31:0] w);
    case (w & 32'h7F)
      32'h37: return 0;
      32'h17: return 1;
      32'h6F: return 2;
      32'h67: return 3;
      32'h63: return 4;
      32'h03: return 5;
      32'h23: return 6;
      32'h13: return 7;
      32'h33: return 8;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] w);
    int c;
    int v;
    c = m_class(w);
    if (c == 0 || c == 1) return w & 32'hFFFF_F000;
    if (c == 3 || c == 5 || c == 7) return 32'($signed(w) >>> 20);
    if (c == 6) return 32'((($signed(w) >>> 25) * 32) + int'((w >> 7) & 31));
    if (c == 4) begin
      v = int'(((w >> 8) & 15) * 2 + ((w >> 25) & 63) * 32 + ((w >> 7) & 1) * 2048);
      if (w[31]) v = v - 4096;
      return 32'(v);
    end
    if (c == 2) begin
      v = int'(((w >> 21) & 1023) * 2 + ((w >> 20) & 1) * 2048 + ((w >> 12) & 255) * 4096);
      if (w[31]) v = v - (1 << 20);
      return 32'(v);
    end
    return 32'h0;
  endfunction

  function automatic int m_rd(input logic [31:0] w);
    int c;
    c = m_class(w);
    if (c == 4 || c == 6 || c == 15) return 0;
    return int'((w >> 7) & 31);
  endfunction

  function automatic bit m_uses1(input logic [31:0] w);
    return m_class(w) inside {3, 4, 5, 6, 7, 8};
  endfunction

  function automatic bit m_uses2(input logic [31:0] w);
    return m_class(w) inside {4, 6, 8};
  endfunction

  function automatic bit m_stall(input logic [31:0] w, input logic [31:0] busy);
    int a;
    int b;
    a = int'((w >> 15) & 31);
    b = int'((w >> 20) & 31);
    return (m_uses1(w) && a != 0 && busy[a]) || (m_uses2(w) && b != 0 && busy[b]);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] opcs [10];
    logic [31:0] r;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};
    r = $urandom();
    return {r[31:7], opcs[$urandom_range(0, 9)]};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int imm);
    return 32'((imm << 20) | (rd << 7) | 32'h13);
  endfunction

  initial begin
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] exp_busy;
    logic [31:0] pc;

    bus_if.startSig = 0;
    bus_if.interrupt_start = 0;
    bus_if.fetch_data = 0;
    bus_if.fetch_cur_pc = 0;
    bus_if.fetch_nxt_pc = 0;
    bus_if.beforePipReadyToSend = 0;
    bus_if.nextPipReadyToRcv = 0;
    bus_if.wb_en = 0;
    bus_if.wb_idx = 0;

    tick();
    tick();
    chk("rst_send", 32'(bus_if.curPipReadyToSend), 0);
    chk("rst_rcv", 32'(bus_if.curPipReadyToRcv), 0);
    chk("rst_op", 32'(bus_if.dec_op), 0);
    chk("rst_imm", bus_if.dec_imm, 0);
    chk("rst_pc", bus_if.dec_cur_pc, 0);
    chk("rst_busy", dut.r_busy, 0);
    rst = 0;
    tick();
    chk("idle_rcv", 32'(bus_if.curPipReadyToRcv), 0);

    // startSig beats a simultaneous offer from fetch
    bus_if.startSig = 1;
    bus_if.fetch_data = 32'h0050_0093;
    bus_if.fetch_cur_pc = 32'h100;
    bus_if.fetch_nxt_pc = 32'h104;
    bus_if.beforePipReadyToSend = 1;
    tick();
    bus_if.startSig = 0;
    chk("start_send", 32'(bus_if.curPipReadyToSend), 0);
    chk("start_rcv", 32'(bus_if.curPipReadyToRcv), 1);

    // addi x1,x0,5
    tick();
    bus_if.beforePipReadyToSend = 0;
    #1;
    chk("addi_send", 32'(bus_if.curPipReadyToSend), 1);
    chk("addi_op", 32'(bus_if.dec_op), 7);
    chk("addi_rd", 32'(bus_if.dec_rd_idx), 1);
    chk("addi_imm", bus_if.dec_imm, 5);
    chk("addi_nxt", bus_if.dec_nxt_pc, 32'h104);
    chk("addi_cur", bus_if.dec_cur_pc, 32'h100);
    chk("addi_rcv_blocked", 32'(bus_if.curPipReadyToRcv), 0);

    // add x2,x1,x1 accepted in the same cycle addi is sent
    bus_if.nextPipReadyToRcv = 1;
    bus_if.fetch_data = 32'h0010_8133;
    bus_if.fetch_cur_pc = 32'h104;
    bus_if.fetch_nxt_pc = 32'h108;
    bus_if.beforePipReadyToSend = 1;
    #1;
    chk("b2b_rcv", 32'(bus_if.curPipReadyToRcv), 1);
    tick();
    bus_if.beforePipReadyToSend = 0;
    #1;
    chk("busy1", dut.r_busy, 32'h2);
    chk("add_stall", 32'(bus_if.curPipReadyToSend), 0);
    chk("add_op", 32'(bus_if.dec_op), 8);
    chk("add_rcv", 32'(bus_if.curPipReadyToRcv), 0);
    tick();
    chk("add_still_stall", 32'(bus_if.curPipReadyToSend), 0);
    bus_if.wb_en = 1;
    bus_if.wb_idx = 1;
    tick();
    bus_if.wb_en = 0;
    #1;
    chk("add_unstall", 32'(bus_if.curPipReadyToSend), 1);
    chk("add_rs1_idx", 32'(bus_if.rf_rs1_idx), 1);
    chk("add_rs2_idx", 32'(bus_if.rf_rs2_idx), 1);
    chk("add_rs1_val", bus_if.dec_rs1_val, 32'hA000_0001);

    // beq x0,x0,-4
    bus_if.fetch_data = 32'hFE00_0EE3;
    bus_if.fetch_cur_pc = 32'h108;
    bus_if.fetch_nxt_pc = 32'h10C;
    bus_if.beforePipReadyToSend = 1;
    tick();
    chk("beq_op", 32'(bus_if.dec_op), 4);
    chk("beq_imm", bus_if.dec_imm, 32'hFFFF_FFFC);
    chk("beq_rd", 32'(bus_if.dec_rd_idx), 0);
    chk("beq_send", 32'(bus_if.curPipReadyToSend), 1);
    chk("busy2", dut.r_busy, 32'h4);

    // lui x5,0x12345 held under backpressure
    bus_if.fetch_data = 32'h1234_52B7;
    bus_if.fetch_cur_pc = 32'h10C;
    bus_if.fetch_nxt_pc = 32'h110;
    tick();
    chk("beq_no_busy", dut.r_busy, 32'h4);
    bus_if.nextPipReadyToRcv = 0;
    bus_if.fetch_data = 32'h0000_0013;
    bus_if.fetch_cur_pc = 32'h110;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("lui_rcv", 32'(bus_if.curPipReadyToRcv), 0);
      chk("lui_send", 32'(bus_if.curPipReadyToSend), 1);
      chk("lui_imm", bus_if.dec_imm, 32'h1234_5000);
      chk("lui_rd", 32'(bus_if.dec_rd_idx), 5);
      chk("lui_pc", bus_if.dec_cur_pc, 32'h10C);
      tick();
    end
    bus_if.nextPipReadyToRcv = 1;
    bus_if.beforePipReadyToSend = 0;
    tick();
    chk("lui_sent", 32'(bus_if.curPipReadyToSend), 0);
    chk("lui_wait_rcv", 32'(bus_if.curPipReadyToRcv), 1);
    chk("busy5", dut.r_busy, 32'h24);

    // four addi streamed back to back
    pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      bus_if.fetch_data = addi(10 + i, i + 1);
      bus_if.fetch_cur_pc = pc;
      bus_if.fetch_nxt_pc = pc + 4;
      bus_if.beforePipReadyToSend = 1;
      tick();
      chk("strm_imm", bus_if.dec_imm, 32'(i + 1));
      chk("strm_pc", bus_if.dec_cur_pc, pc);
      chk("strm_send", 32'(bus_if.curPipReadyToSend), 1);
      chk("strm_rcv", 32'(bus_if.curPipReadyToRcv), 1);
      pc = pc + 4;
    end
    bus_if.beforePipReadyToSend = 0;
    tick();
    chk("strm_busy", dut.r_busy, 32'h3C24);

    // add x3,x5,x0 stalls on x5, then flushed
    bus_if.fetch_data = 32'h0002_81B3;
    bus_if.beforePipReadyToSend = 1;
    tick();
    bus_if.beforePipReadyToSend = 0;
    #1;
    chk("flush_pre_stall", 32'(bus_if.curPipReadyToSend), 0);
    bus_if.interrupt_start = 1;
    tick();
    bus_if.interrupt_start = 0;
    #1;
    chk("flush_send", 32'(bus_if.curPipReadyToSend), 0);
    chk("flush_rcv", 32'(bus_if.curPipReadyToRcv), 1);
    chk("flush_busy", dut.r_busy, 0);

    bus_if.nextPipReadyToRcv = 0;
    bus_if.fetch_data = 32'hFFFF_FFFF;
    bus_if.beforePipReadyToSend = 1;
    tick();
    bus_if.beforePipReadyToSend = 0;
    #1;
    chk("ill_flag", 32'(bus_if.dec_illegal), 1);
    chk("ill_op", 32'(bus_if.dec_op), 15);
    chk("ill_rd", 32'(bus_if.dec_rd_idx), 0);
    chk("ill_imm", bus_if.dec_imm, 0);
    chk("ill_send", 32'(bus_if.curPipReadyToSend), 1);

    // asynchronous reset while holding
    rst = 1;
    #1;
    chk("arst_send", 32'(bus_if.curPipReadyToSend), 0);
    chk("arst_rcv", 32'(bus_if.curPipReadyToRcv), 0);
    chk("arst_ill", 32'(bus_if.dec_illegal), 0);
    tick();
    rst = 0;

    // randomized decode and scoreboard checks
    for (int n = 0; n < 40; n++) begin
      bus_if.interrupt_start = 1;
      bus_if.nextPipReadyToRcv = 0;
      tick();
      bus_if.interrupt_start = 0;
      w1 = gen_instr();
      bus_if.fetch_data = w1;
      bus_if.fetch_cur_pc = 32'($urandom());
      bus_if.beforePipReadyToSend = 1;
      tick();
      bus_if.beforePipReadyToSend = 0;
      #1;
      chk("rnd_op", 32'(bus_if.dec_op), 32'(m_class(w1)));
      chk("rnd_imm", bus_if.dec_imm, m_imm(w1));
      chk("rnd_rd", 32'(bus_if.dec_rd_idx), 32'(m_rd(w1)));
      chk("rnd_f3", 32'(bus_if.dec_funct3), (w1 >> 12) & 7);
      chk("rnd_f7", 32'(bus_if.dec_funct7b5), (w1 >> 30) & 1);
      chk("rnd_ill", 32'(bus_if.dec_illegal), 32'(m_class(w1) == 15));
      chk("rnd_send", 32'(bus_if.curPipReadyToSend), 1);
      bus_if.nextPipReadyToRcv = 1;
      tick();
      exp_busy = (m_rd(w1) != 0) ? (32'h1 << m_rd(w1)) : 32'h0;
      chk("rnd_busy_set", dut.r_busy, exp_busy);

      w2 = gen_instr();
      bus_if.fetch_data = w2;
      bus_if.nextPipReadyToRcv = 0;
      bus_if.beforePipReadyToSend = 1;
      tick();
      bus_if.beforePipReadyToSend = 0;
      #1;
      chk("rnd_stall", 32'(bus_if.curPipReadyToSend), 32'(!m_stall(w2, exp_busy)));
      bus_if.wb_en = 1;
      bus_if.wb_idx = 5'(m_rd(w1));
      tick();
      bus_if.wb_en = 0;
      #1;
      chk("rnd_unstall", 32'(bus_if.curPipReadyToSend), 1);

      // send while writeback clears the same register: set must win
      bus_if.nextPipReadyToRcv = 1;
      bus_if.wb_en = 1;
      bus_if.wb_idx = 5'(m_rd(w2));
      tick();
      bus_if.wb_en = 0;
      exp_busy = (m_rd(w2) != 0) ? (32'h1 << m_rd(w2)) : 32'h0;
      chk("rnd_set_wins", dut.r_busy, exp_busy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
